pulse_burst_ctrl: RTL and testbench

Sequencer for the pulse stretcher datapath. It consumes the registered configuration word and the trigger bit from the register stage (config_reg_0, pulse_reg_0). On each trigger rising edge it emits a burst of stretched pulses with programmable high width, low gap and pulse count. It reports busy, done and overrun status back to the register/readout side.

---
 rtl/pulse_burst_ctrl_if.sv | 22 ++
 rtl/pulse_burst_ctrl.sv | 129 ++++++++++++
 tb/tb_pulse_burst_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_burst_ctrl_if.sv
// pulse_burst_ctrl_if: configuration, trigger and status bundle between the register stage and the burst sequencer
interface pulse_burst_ctrl_if #(
    parameter int COUNT_BITS = 4
);
    logic [15:0]           config_reg_0;
    logic                  pulse_reg_0;
    logic                  abort;
    logic                  clr_ovr;
    logic                  pulse_out;
    logic                  busy;
    logic                  done;
    logic                  overrun;
    logic [COUNT_BITS-1:0] pulse_idx;
    modport master (
        output config_reg_0, pulse_reg_0, abort, clr_ovr,
        input  pulse_out, busy, done, overrun, pulse_idx
    );
    modport slave (
        input  config_reg_0, pulse_reg_0, abort, clr_ovr,
        output pulse_out, busy, done, overrun, pulse_idx
    );
endinterface

// File: rtl/pulse_burst_ctrl.sv
// pulse_burst_ctrl: trigger-driven burst sequencer with programmable width, gap and count; PULSE_BURST_RETRIG_EN enables restart on a busy trigger
module pulse_burst_ctrl #(
    parameter int WIDTH_BITS = 8,
    parameter int GAP_BITS   = 4,
    parameter int COUNT_BITS = 4
) (
    input  logic                    CLK1,
    input  logic                    RESET,
    pulse_burst_ctrl_if.slave       bus
);
    localparam int CW = (WIDTH_BITS > GAP_BITS) ? WIDTH_BITS : GAP_BITS;

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_GAP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         wld_q, wld_d;
    logic [CW-1:0]         gld_q, gld_d;
    logic [COUNT_BITS-1:0] last_q, last_d;
    logic [COUNT_BITS-1:0] idx_q, idx_d;
    logic                  prev_q;
    logic                  pulse_q, pulse_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovr_q, ovr_d;

    logic [WIDTH_BITS-1:0] w_raw;
    logic [GAP_BITS-1:0]   g_raw;
    logic [COUNT_BITS-1:0] n_raw;
    logic [CW-1:0]         w_load, g_load;
    logic                  rise, in_burst, start;

    // Zero width/gap mean one cycle; counter holds cycles remaining minus one.
    // A zero count field wraps to the all-ones last index, i.e. 2^COUNT_BITS pulses.
    assign w_raw    = bus.config_reg_0[WIDTH_BITS-1:0];
    assign g_raw    = bus.config_reg_0[WIDTH_BITS +: GAP_BITS];
    assign n_raw    = bus.config_reg_0[WIDTH_BITS+GAP_BITS +: COUNT_BITS];
    assign w_load   = (w_raw == '0) ? '0 : CW'(w_raw - WIDTH_BITS'(1));
    assign g_load   = (g_raw == '0) ? '0 : CW'(g_raw - GAP_BITS'(1));
    assign rise     = bus.pulse_reg_0 & ~prev_q;
    assign in_burst = state_q != S_IDLE;
`ifdef PULSE_BURST_RETRIG_EN
    assign start    = rise & (~in_burst | ~bus.abort);
`else
    assign start    = rise & ~in_burst;
`endif

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK1) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wld_q   <= '0;
            gld_q   <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wld_q   <= wld_d;
            gld_q   <= gld_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            prev_q  <= bus.pulse_reg_0;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state: start/capture, abort, phase countdown and pulse sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wld_d   = wld_q;
        gld_d   = gld_q;
        last_d  = last_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        ovr_d   = (in_burst && rise) ? 1'b1 : (bus.clr_ovr ? 1'b0 : ovr_q);
        if (start) begin
            state_d = S_HIGH;
            cnt_d   = w_load;
            wld_d   = w_load;
            gld_d   = g_load;
            last_d  = n_raw - COUNT_BITS'(1);
            idx_d   = '0;
        end else begin
            case (state_q)
                S_HIGH, S_GAP: begin
                    if (bus.abort) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (state_q == S_GAP) begin
                        state_d = S_HIGH;
                        cnt_d   = wld_q;
                        idx_d   = idx_q + COUNT_BITS'(1);
                    end else if (idx_q == last_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = gld_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs: registered pulse/busy follow the next state; status driven from registers
    always_comb begin
        pulse_d       = state_d == S_HIGH;
        busy_d        = state_d != S_IDLE;
        bus.pulse_out = pulse_q;
        bus.busy      = busy_q;
        bus.done      = done_q;
        bus.overrun   = ovr_q;
        bus.pulse_idx = idx_q;
    end
endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// tb_pulse_burst_ctrl: directed self-checking bench for pulse_burst_ctrl
module tb_pulse_burst_ctrl;
    logic CLK1 = 1'b0;
    logic RESET = 1'b1;
    int checks = 0;
    int failures = 0;

    pulse_burst_ctrl_if #(.COUNT_BITS(4)) bus ();

    pulse_burst_ctrl #(.WIDTH_BITS(8), .GAP_BITS(4), .COUNT_BITS(4)) dut (
        .CLK1  (CLK1),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK1 = ~CLK1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK1);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        bus.pulse_reg_0 = 1'b0;
        bus.abort = 1'b0;
        bus.clr_ovr = 1'b0;
        bus.config_reg_0 = 16'h0000;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done, bus.overrun, bus.pulse_idx} !== 8'h00) begin
            failures++;
            $display("FAIL reset got=%b exp=00000000", {bus.pulse_out, bus.busy, bus.done, bus.overrun, bus.pulse_idx});
        end
        tick();
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=000", {bus.pulse_out, bus.busy, bus.done});
        end
    endtask

    task automatic test_basic();
        logic [7:0] ep = 8'b0111_0111;
        logic [7:0] eb = 8'b0111_1111;
        logic [7:0] ed = 8'b1000_0000;
        logic [7:0] ei = 8'b1111_0000;
        do_reset();
        bus.config_reg_0 = 16'h2103;
        bus.pulse_reg_0 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.pulse_reg_0 = 1'b0;
            checks++;
            if ({bus.pulse_out, bus.busy, bus.done} !== {ep[c-1], eb[c-1], ed[c-1]}) begin
                failures++;
                $display("FAIL basic cyc%0d pulse/busy/done got=%b exp=%b", c, {bus.pulse_out, bus.busy, bus.done}, {ep[c-1], eb[c-1], ed[c-1]});
            end
            checks++;
            if (bus.pulse_idx !== {3'b000, ei[c-1]}) begin
                failures++;
                $display("FAIL basic_idx cyc%0d got=%0d exp=%0d", c, bus.pulse_idx, ei[c-1]);
            end
        end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_once got=%b exp=0", bus.done);
        end
    endtask

    task automatic test_count_zero();
        do_reset();
        bus.config_reg_0 = 16'h0000;
        bus.pulse_reg_0 = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            tick();
            bus.pulse_reg_0 = 1'b0;
            checks++;
            if ({bus.pulse_out, bus.busy, bus.done} !== {c <= 31 && c % 2 == 1, c <= 31, c == 32}) begin
                failures++;
                $display("FAIL zero_cfg cyc%0d pulse/busy/done got=%b exp=%b", c, {bus.pulse_out, bus.busy, bus.done}, {c <= 31 && c % 2 == 1, c <= 31, c == 32});
            end
            if (c <= 31) begin
                checks++;
                if (bus.pulse_idx !== 4'((c - 1) / 2)) begin
                    failures++;
                    $display("FAIL zero_cfg_idx cyc%0d got=%0d exp=%0d", c, bus.pulse_idx, (c - 1) / 2);
                end
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        bus.config_reg_0 = 16'h1005;
        bus.pulse_reg_0 = 1'b1;
        tick();
        bus.pulse_reg_0 = 1'b0;
        tick();
        bus.pulse_reg_0 = 1'b1;
        tick();
        bus.pulse_reg_0 = 1'b0;
        checks++;
        if ({bus.overrun, bus.pulse_out, bus.pulse_idx} !== 6'b11_0000) begin
            failures++;
            $display("FAIL overrun_set got=%b exp=110000", {bus.overrun, bus.pulse_out, bus.pulse_idx});
        end
`ifndef PULSE_BURST_RETRIG_EN
        tick();
        tick();
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== 3'b110) begin
            failures++;
            $display("FAIL overrun_burst_c5 got=%b exp=110", {bus.pulse_out, bus.busy, bus.done});
        end
        tick();
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done, bus.overrun} !== 4'b0011) begin
            failures++;
            $display("FAIL overrun_burst_c6 got=%b exp=0011", {bus.pulse_out, bus.busy, bus.done, bus.overrun});
        end
`else
        for (int c = 0; c < 7; c++) tick();
`endif
        bus.pulse_reg_0 = 1'b1;
        tick();
        bus.pulse_reg_0 = 1'b0;
        tick();
        bus.pulse_reg_0 = 1'b1;
        bus.clr_ovr = 1'b1;
        tick();
        bus.pulse_reg_0 = 1'b0;
        bus.clr_ovr = 1'b0;
        checks++;
        if ({bus.busy, bus.overrun} !== 2'b11) begin
            failures++;
            $display("FAIL overrun_set_wins got=%b exp=11", {bus.busy, bus.overrun});
        end
        bus.clr_ovr = 1'b1;
        tick();
        bus.clr_ovr = 1'b0;
        checks++;
        if (bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear got=%b exp=0", bus.overrun);
        end
    endtask

    task automatic test_abort();
        do_reset();
        bus.config_reg_0 = 16'h1010;
        bus.pulse_reg_0 = 1'b1;
        tick();
        bus.pulse_reg_0 = 1'b0;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done, bus.pulse_idx} !== 7'b000_0000) begin
            failures++;
            $display("FAIL abort got=%b exp=0000000", {bus.pulse_out, bus.busy, bus.done, bus.pulse_idx});
        end
        bus.pulse_reg_0 = 1'b1;
        tick();
        bus.pulse_reg_0 = 1'b0;
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done, bus.pulse_idx} !== 7'b110_0000) begin
            failures++;
            $display("FAIL abort_restart got=%b exp=1100000", {bus.pulse_out, bus.busy, bus.done, bus.pulse_idx});
        end
        tick();
        bus.abort = 1'b1;
        bus.pulse_reg_0 = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.pulse_reg_0 = 1'b0;
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== 3'b000) begin
            failures++;
            $display("FAIL abort_beats_rise got=%b exp=000", {bus.pulse_out, bus.busy, bus.done});
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== 3'b000) begin
            failures++;
            $display("FAIL abort_idle got=%b exp=000", {bus.pulse_out, bus.busy, bus.done});
        end
    endtask

    task automatic test_shadow();
        do_reset();
        bus.config_reg_0 = 16'h1008;
        bus.pulse_reg_0 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            bus.pulse_reg_0 = 1'b0;
            bus.config_reg_0 = 16'h1001;
            checks++;
            if ({bus.pulse_out, bus.done} !== {c <= 8, c == 9}) begin
                failures++;
                $display("FAIL shadow cyc%0d pulse/done got=%b exp=%b", c, {bus.pulse_out, bus.done}, {c <= 8, c == 9});
            end
        end
        tick();
        bus.pulse_reg_0 = 1'b1;
        tick();
        bus.pulse_reg_0 = 1'b0;
        checks++;
        if ({bus.pulse_out, bus.busy} !== 2'b11) begin
            failures++;
            $display("FAIL shadow_next_c1 got=%b exp=11", {bus.pulse_out, bus.busy});
        end
        tick();
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== 3'b001) begin
            failures++;
            $display("FAIL shadow_next_c2 got=%b exp=001", {bus.pulse_out, bus.busy, bus.done});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.config_reg_0 = 16'h1002;
        bus.pulse_reg_0 = 1'b1;
        tick();
        bus.pulse_reg_0 = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== 3'b001) begin
            failures++;
            $display("FAIL b2b_done got=%b exp=001", {bus.pulse_out, bus.busy, bus.done});
        end
        bus.pulse_reg_0 = 1'b1;
        tick();
        bus.pulse_reg_0 = 1'b0;
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done, bus.overrun} !== 4'b1100) begin
            failures++;
            $display("FAIL b2b_start got=%b exp=1100", {bus.pulse_out, bus.busy, bus.done, bus.overrun});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.config_reg_0 = 16'h1005;
        bus.pulse_reg_0 = 1'b1;
        tick();
        bus.pulse_reg_0 = 1'b0;
        tick();
        bus.pulse_reg_0 = 1'b1;
        tick();
        bus.pulse_reg_0 = 1'b0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done, bus.overrun, bus.pulse_idx} !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid got=%b exp=00000000", {bus.pulse_out, bus.busy, bus.done, bus.overrun, bus.pulse_idx});
        end
        tick();
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_after got=%b exp=00", {bus.busy, bus.done});
        end
    endtask

`ifdef PULSE_BURST_RETRIG_EN
    task automatic test_retrig();
        logic [7:0] ep = 8'b0111_0111;
        do_reset();
        bus.config_reg_0 = 16'h2103;
        bus.pulse_reg_0 = 1'b1;
        tick();
        bus.pulse_reg_0 = 1'b0;
        for (int c = 2; c <= 5; c++) tick();
        bus.pulse_reg_0 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.pulse_reg_0 = 1'b0;
            checks++;
            if ({bus.pulse_out, bus.done, bus.overrun} !== {ep[c-1], c == 8, 1'b1}) begin
                failures++;
                $display("FAIL retrig cyc%0d pulse/done/ovr got=%b exp=%b", c, {bus.pulse_out, bus.done, bus.overrun}, {ep[c-1], c == 8, 1'b1});
            end
            if (c == 1) begin
                checks++;
                if (bus.pulse_idx !== 4'd0) begin
                    failures++;
                    $display("FAIL retrig_idx got=%0d exp=0", bus.pulse_idx);
                end
            end
        end
    endtask
`endif

    initial begin
        bus.config_reg_0 = 16'h0000;
        bus.pulse_reg_0 = 1'b0;
        bus.abort = 1'b0;
        bus.clr_ovr = 1'b0;
        test_reset();
        test_basic();
        test_count_zero();
        test_overrun();
        test_abort();
        test_shadow();
        test_back_to_back();
        test_reset_mid();
`ifdef PULSE_BURST_RETRIG_EN
        test_retrig();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
